// File: rtl/axil_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axil_rd_arbiter
//
// Shares one AXI4-Lite read port on the memory slave between two masters:
// the Fetch stage (master 0, "if") and the load/store unit (master 1, "ls").
// Only one read is in flight at a time. The LSU wins contested arbitrations,
// except that after STARVE_LIMIT consecutive contested LSU wins, fetch wins
// the next contested arbitration.
//
// Parameters
//   ADDR_WIDTH    width of every AR address
//   DATA_WIDTH    width of every R data bus
//   STARVE_LIMIT  contested LSU wins tolerated before fetch is forced (>=1)
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   i_if_axil_ar*/o_if_axil_arready   fetch AR channel
//   o_if_axil_r*/i_if_axil_rready     fetch R channel
//   i_ls_axil_ar*/o_ls_axil_arready   LSU AR channel
//   o_ls_axil_r*/i_ls_axil_rready     LSU R channel
//   o_axil_ar*/i_axil_arready         slave AR channel (address/valid registered)
//   i_axil_r*/o_axil_rready           slave R channel
//   o_grant                           owner of current transaction (0 fetch, 1 LSU)
//   o_busy                            a transaction is in its address or data phase
// ---------------------------------------------------------------------------
module axil_rd_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_if_axil_araddr,
    input  logic                  i_if_axil_arvalid,
    output logic                  o_if_axil_arready,
    output logic [DATA_WIDTH-1:0] o_if_axil_rdata,
    output logic                  o_if_axil_rvalid,
    input  logic                  i_if_axil_rready,

    input  logic [ADDR_WIDTH-1:0] i_ls_axil_araddr,
    input  logic                  i_ls_axil_arvalid,
    output logic                  o_ls_axil_arready,
    output logic [DATA_WIDTH-1:0] o_ls_axil_rdata,
    output logic                  o_ls_axil_rvalid,
    input  logic                  i_ls_axil_rready,

    output logic [ADDR_WIDTH-1:0] o_axil_araddr,
    output logic                  o_axil_arvalid,
    input  logic                  i_axil_arready,
    input  logic [DATA_WIDTH-1:0] i_axil_rdata,
    input  logic                  i_axil_rvalid,
    output logic                  o_axil_rready,

    output logic                  o_grant,
    output logic                  o_busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] starve_cnt;

    logic starve_full;
    logic pick_ls;
    logic pick_if;
    logic in_idle;
    logic in_data;

    // Arbitration and channel steering. The LSU wins whenever it asks,
    // unless fetch is also asking and has already lost STARVE_LIMIT
    // contested rounds in a row. Master-facing handshake signals are
    // forced low while reset is asserted so no master sees a phantom
    // handshake during reset.
    always_comb begin
        starve_full = (starve_cnt == CW'(STARVE_LIMIT));
        pick_ls     = i_ls_axil_arvalid && !(i_if_axil_arvalid && starve_full);
        pick_if     = i_if_axil_arvalid && !pick_ls;
        in_idle     = (state == S_IDLE) && !rst;
        in_data     = (state == S_DATA) && !rst;

        o_if_axil_arready = in_idle && pick_if;
        o_ls_axil_arready = in_idle && pick_ls;

        o_axil_rready    = in_data && (o_grant ? i_ls_axil_rready : i_if_axil_rready);
        o_if_axil_rvalid = in_data && !o_grant && i_axil_rvalid;
        o_ls_axil_rvalid = in_data &&  o_grant && i_axil_rvalid;
    end

    // Read data fans out to both masters; only rvalid says whose it is.
    assign o_if_axil_rdata = i_axil_rdata;
    assign o_ls_axil_rdata = i_axil_rdata;
    assign o_busy          = (state != S_IDLE);

    // Transaction sequencing: accept one master request in IDLE, present
    // it to the slave from a register in ADDR, then forward the response
    // to the owner in DATA. The fetch starvation counter only moves in
    // IDLE; it clears whenever fetch is not asking or is granted, and
    // counts LSU wins taken while fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            o_axil_arvalid <= 1'b0;
            o_axil_araddr  <= '0;
            o_grant        <= 1'b0;
            starve_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (o_ls_axil_arready) begin
                        o_axil_araddr  <= i_ls_axil_araddr;
                        o_grant        <= 1'b1;
                        o_axil_arvalid <= 1'b1;
                        state          <= S_ADDR;
                    end else if (o_if_axil_arready) begin
                        o_axil_araddr  <= i_if_axil_araddr;
                        o_grant        <= 1'b0;
                        o_axil_arvalid <= 1'b1;
                        state          <= S_ADDR;
                    end

                    if (!i_if_axil_arvalid || o_if_axil_arready) begin
                        starve_cnt <= '0;
                    end else if (o_ls_axil_arready && !starve_full) begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                end

                S_ADDR: begin
                    if (i_axil_arready) begin
                        o_axil_arvalid <= 1'b0;
                        state          <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (i_axil_rvalid && o_axil_rready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    o_axil_arvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_rd_arbiter
//
// Drives axil_rd_arbiter with two AXI-Lite read masters and a memory slave
// whose read data is a fixed function of the address. A transaction-level
// model of the arbiter (busy/owner/address plus a count of contested LSU
// wins) predicts every DUT output each cycle. Directed scenarios cover
// single reads, contention, starvation, AR and R backpressure and reset
// mid-transaction; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_axil_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] if_araddr = '0;
    logic          if_arvalid = 1'b0;
    logic          if_rready = 1'b1;
    logic [AW-1:0] ls_araddr = '0;
    logic          ls_arvalid = 1'b0;
    logic          ls_rready = 1'b1;
    logic          s_arready = 1'b1;
    logic [DW-1:0] s_rdata = '0;
    logic          s_rvalid = 1'b0;

    logic          if_arready, if_rvalid, ls_arready, ls_rvalid;
    logic [DW-1:0] if_rdata, ls_rdata;
    logic [AW-1:0] m_araddr;
    logic          m_arvalid, m_rready, grant, busy;

    always #5 clk = ~clk;

    axil_rd_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_if_axil_araddr  (if_araddr),
        .i_if_axil_arvalid (if_arvalid),
        .o_if_axil_arready (if_arready),
        .o_if_axil_rdata   (if_rdata),
        .o_if_axil_rvalid  (if_rvalid),
        .i_if_axil_rready  (if_rready),
        .i_ls_axil_araddr  (ls_araddr),
        .i_ls_axil_arvalid (ls_arvalid),
        .o_ls_axil_arready (ls_arready),
        .o_ls_axil_rdata   (ls_rdata),
        .o_ls_axil_rvalid  (ls_rvalid),
        .i_ls_axil_rready  (ls_rready),
        .o_axil_araddr     (m_araddr),
        .o_axil_arvalid    (m_arvalid),
        .i_axil_arready    (s_arready),
        .i_axil_rdata      (s_rdata),
        .i_axil_rvalid     (s_rvalid),
        .o_axil_rready     (m_rready),
        .o_grant           (grant),
        .o_busy            (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Environment knobs
    bit auto_mode    = 1'b0;
    bit keep_req     = 1'b0;
    int req_pct      = 0;
    int ar_ready_pct = 100;
    int r_delay_max  = 0;
    int rready_pct   = 100;

    // Slave bookkeeping and fetch-wait statistics from observed handshakes
    bit            sl_has = 1'b0;
    logic [AW-1:0] sl_addr = '0;
    int            sl_delay = 0;
    int            sl_ar_hs = 0;
    int            sl_r_hs = 0;
    int            fetch_wait = 0;
    int            max_fetch_wait = 0;

    // Transaction-level reference model
    bit            md_busy = 1'b0;
    bit            md_ar_pend = 1'b0;
    bit            md_owner = 1'b0;
    logic [AW-1:0] md_addr = '0;
    int            md_starve = 0;
    bit            grant_owner[$];
    logic [AW-1:0] grant_addr[$];

    logic e_ls_win, e_if_arready, e_ls_arready, e_data;
    logic e_rready, e_if_rvalid, e_ls_rvalid;

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // What the outputs must be, from the arbitration rules and the model.
    always_comb begin
        e_ls_win     = ls_arvalid && !(if_arvalid && (md_starve >= SL));
        e_if_arready = !rst && !md_busy && if_arvalid && !e_ls_win;
        e_ls_arready = !rst && !md_busy && e_ls_win;
        e_data       = !rst && md_busy && !md_ar_pend;
        e_rready     = e_data && (md_owner ? ls_rready : if_rready);
        e_if_rvalid  = e_data && !md_owner && s_rvalid;
        e_ls_rvalid  = e_data &&  md_owner && s_rvalid;
    end

    // Model advance on each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            md_busy    <= 1'b0;
            md_ar_pend <= 1'b0;
            md_owner   <= 1'b0;
            md_addr    <= '0;
            md_starve  <= 0;
        end else if (!md_busy) begin
            if (!if_arvalid || e_if_arready) md_starve <= 0;
            else if (e_ls_arready)           md_starve <= (md_starve < SL) ? md_starve + 1 : SL;
            if (e_ls_arready) begin
                md_busy <= 1'b1; md_ar_pend <= 1'b1; md_owner <= 1'b1; md_addr <= ls_araddr;
                grant_owner.push_back(1'b1);
                grant_addr.push_back(ls_araddr);
            end else if (e_if_arready) begin
                md_busy <= 1'b1; md_ar_pend <= 1'b1; md_owner <= 1'b0; md_addr <= if_araddr;
                grant_owner.push_back(1'b0);
                grant_addr.push_back(if_araddr);
            end
        end else if (md_ar_pend) begin
            if (s_arready) md_ar_pend <= 1'b0;
        end else if (s_rvalid && e_rready) begin
            md_busy <= 1'b0;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        checkOutput("if_arready", if_arready, e_if_arready);
        checkOutput("ls_arready", ls_arready, e_ls_arready);
        checkOutput("if_rvalid", if_rvalid, e_if_rvalid);
        checkOutput("ls_rvalid", ls_rvalid, e_ls_rvalid);
        checkOutput("s_rready", m_rready, e_rready);
        checkOutput("s_arvalid", m_arvalid, md_busy && md_ar_pend);
        checkOutput("s_araddr", m_araddr, md_addr);
        checkOutput("busy", busy, md_busy);
        checkOutput("if_rdata_pass", if_rdata, s_rdata);
        checkOutput("ls_rdata_pass", ls_rdata, s_rdata);
        if (md_busy) checkOutput("grant", grant, md_owner);
        if (e_if_rvalid) checkOutput("if_rdata_addr", if_rdata, slave_data(md_addr));
        if (e_ls_rvalid) checkOutput("ls_rdata_addr", ls_rdata, slave_data(md_addr));
    end

    // Master and slave behaviour: sample handshakes on the falling edge,
    // react just after the following rising edge.
    initial begin
        bit hs_if, hs_ls, hs_sar, hs_sr;
        logic [AW-1:0] cap_addr;
        forever begin
            @(negedge clk);
            hs_if    = if_arvalid && if_arready;
            hs_ls    = ls_arvalid && ls_arready;
            hs_sar   = m_arvalid && s_arready;
            hs_sr    = s_rvalid && m_rready;
            cap_addr = m_araddr;
            if (rst || hs_if || !if_arvalid) fetch_wait = 0;
            else if (hs_ls)                  fetch_wait++;
            if (fetch_wait > max_fetch_wait) max_fetch_wait = fetch_wait;

            @(posedge clk);
            #1;
            if (hs_if) begin
                if (keep_req) if_araddr = $urandom & 32'hFFFF_FFFC;
                else          if_arvalid = 1'b0;
            end
            if (hs_ls) begin
                if (keep_req) ls_araddr = $urandom & 32'hFFFF_FFFC;
                else          ls_arvalid = 1'b0;
            end
            if (auto_mode) begin
                if (!if_arvalid && $urandom_range(99) < req_pct) begin
                    if_arvalid = 1'b1; if_araddr = $urandom & 32'hFFFF_FFFC;
                end
                if (!ls_arvalid && $urandom_range(99) < req_pct) begin
                    ls_arvalid = 1'b1; ls_araddr = $urandom & 32'hFFFF_FFFC;
                end
                if_rready = ($urandom_range(99) < rready_pct);
                ls_rready = ($urandom_range(99) < rready_pct);
            end

            if (rst) begin
                sl_has   = 1'b0;
                s_rvalid = 1'b0;
            end else begin
                if (hs_sr) begin
                    s_rvalid = 1'b0; sl_has = 1'b0; sl_r_hs++;
                end
                if (hs_sar) begin
                    sl_has = 1'b1; sl_addr = cap_addr;
                    sl_delay = $urandom_range(r_delay_max); sl_ar_hs++;
                end
                if (sl_has && !s_rvalid) begin
                    if (sl_delay == 0) begin
                        s_rvalid = 1'b1; s_rdata = slave_data(sl_addr);
                    end else begin
                        sl_delay--;
                    end
                end
            end
            s_arready = ($urandom_range(99) < ar_ready_pct);
        end
    end

    // Raise requests on either or both masters in the same cycle.
    task automatic applyStimulus(input bit use_if, input logic [AW-1:0] a_if,
                                 input bit use_ls, input logic [AW-1:0] a_ls);
        @(posedge clk);
        #2;
        if (use_if) begin if_araddr = a_if; if_arvalid = 1'b1; end
        if (use_ls) begin ls_araddr = a_ls; ls_arvalid = 1'b1; end
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || if_arvalid || ls_arvalid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeoutFail(tag);
    endtask

    initial begin
        int base, n, r_before, ar_before;
        int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_arvalid", m_arvalid, 0);
        checkOutput("rst_araddr", m_araddr, 0);
        checkOutput("rst_rready", m_rready, 0);

        // Fetch-only read of 0x4 against a zero-wait slave
        applyStimulus(1'b1, 32'h4, 1'b0, '0);
        n = 0;
        @(negedge clk);
        while (!(if_arvalid && if_arready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeoutFail("fetch_hs");
        @(negedge clk);
        checkOutput("fetch_araddr_t1", m_araddr, 32'h4);
        checkOutput("fetch_arvalid_t1", m_arvalid, 1);
        @(negedge clk);
        checkOutput("fetch_rvalid_t2", if_rvalid, 1);
        checkOutput("fetch_rdata_t2", if_rdata, 32'hDEAD_0004);
        checkOutput("fetch_ls_rvalid_t2", ls_rvalid, 0);
        @(negedge clk);
        checkOutput("fetch_idle_t3", busy, 0);
        waitIdle("fetch_idle");
        checkOutput("fetch_grant_log", grant_owner[grant_owner.size()-1], 0);

        // Contested: LSU 0x200 first, then fetch 0x100
        base = grant_owner.size();
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h200);
        waitIdle("contest_idle");
        if (grant_owner.size() >= base + 2) begin
            checkOutput("contest_first_owner", grant_owner[base], 1);
            checkOutput("contest_first_addr", grant_addr[base], 32'h200);
            checkOutput("contest_second_owner", grant_owner[base+1], 0);
            checkOutput("contest_second_addr", grant_addr[base+1], 32'h100);
        end else timeoutFail("contest_grants");

        // Both masters requesting continuously: starvation guard pattern
        base = grant_owner.size();
        keep_req = 1'b1;
        applyStimulus(1'b1, 32'h1000, 1'b1, 32'h2000);
        n = 0;
        while (grant_owner.size() < base + 10 && n < 300) begin @(negedge clk); n++; end
        keep_req = 1'b0;
        if (n >= 300) timeoutFail("starve_grants");
        waitIdle("starve_idle");
        for (int i = 0; i < 10; i++)
            if (grant_owner.size() > base + i)
                checkOutput($sformatf("starve_seq_%0d", i), grant_owner[base+i], exp_seq[i]);

        // Slave holds arready low for 3 cycles
        ar_before = sl_ar_hs;
        ar_ready_pct = 0;
        applyStimulus(1'b1, 32'h304, 1'b1, 32'h300);
        n = 0;
        @(negedge clk);
        while (!m_arvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeoutFail("stall_arvalid");
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall_arvalid_%0d", i), m_arvalid, 1);
            checkOutput($sformatf("stall_araddr_%0d", i), m_araddr, 32'h300);
            checkOutput($sformatf("stall_if_arready_%0d", i), if_arready, 0);
            checkOutput($sformatf("stall_ls_arready_%0d", i), ls_arready, 0);
            if (i < 2) @(negedge clk);
        end
        ar_ready_pct = 100;
        waitIdle("stall_idle");
        checkOutput("stall_ar_handshakes", sl_ar_hs - ar_before, 2);

        // LSU holds rready low for 2 cycles after the slave responds
        r_before = sl_r_hs;
        ls_rready = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 32'h400);
        n = 0;
        @(negedge clk);
        while (!ls_rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeoutFail("rbp_rvalid");
        checkOutput("rbp_rready_0", m_rready, 0);
        @(negedge clk);
        checkOutput("rbp_rvalid_1", ls_rvalid, 1);
        checkOutput("rbp_rready_1", m_rready, 0);
        @(posedge clk);
        #2 ls_rready = 1'b1;
        @(negedge clk);
        checkOutput("rbp_rready_2", m_rready, 1);
        checkOutput("rbp_rdata_2", ls_rdata, 32'hDEAD_0400);
        waitIdle("rbp_idle");
        checkOutput("rbp_r_handshakes", sl_r_hs - r_before, 1);

        // Reset while in the data phase, then a normal read
        if_rready = 1'b0;
        applyStimulus(1'b1, 32'h500, 1'b0, '0);
        n = 0;
        @(negedge clk);
        while (!(busy && !m_arvalid) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeoutFail("rstdata_reach");
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        if_rready = 1'b1;
        @(negedge clk);
        checkOutput("rstdata_busy", busy, 0);
        checkOutput("rstdata_arvalid", m_arvalid, 0);
        checkOutput("rstdata_if_rvalid", if_rvalid, 0);
        checkOutput("rstdata_ls_rvalid", ls_rvalid, 0);
        applyStimulus(1'b1, 32'h504, 1'b0, '0);
        n = 0;
        @(negedge clk);
        while (!if_rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeoutFail("rstdata_next_rvalid");
        checkOutput("rstdata_next_rdata", if_rdata, 32'hDEAD_0504);
        waitIdle("rstdata_idle");

        // Randomized traffic with occasional reset pulses
        req_pct = 40; ar_ready_pct = 60; r_delay_max = 3; rready_pct = 70;
        auto_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2 rst = ($urandom_range(999) < 3);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        auto_mode = 1'b0; req_pct = 0; ar_ready_pct = 100;
        if_rready = 1'b1; ls_rready = 1'b1;
        waitIdle("random_drain");
        checkOutput("max_fetch_wait_bounded", (max_fetch_wait <= SL), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_rd_arbiter.md
# axil_rd_arbiter

Two-master, one-slave AXI4-Lite read-channel arbiter that shares the single instruction/data memory read port between the Fetch stage (master 0) and the load/store unit (master 1). It sits between the core's memory interfaces and the memory slave (ROM/RAM), carries exactly one outstanding read at a time, and grants the load/store unit priority, with a starvation guard that bounds fetch waiting time.

## Interface
- ADDR_WIDTH, 32, address width of all AR channels
- DATA_WIDTH, 32, data width of all R channels
- STARVE_LIMIT, 4, consecutive contested LSU grants after which fetch wins the next contested arbitration (>=1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_if_axil_araddr  in  ADDR_WIDTH  fetch read address
- i_if_axil_arvalid  in  1  fetch AR valid
- o_if_axil_arready  out  1  fetch AR ready
- o_if_axil_rdata  out  DATA_WIDTH  fetch read data
- o_if_axil_rvalid  out  1  fetch R valid
- i_if_axil_rready  in  1  fetch R ready
- i_ls_axil_araddr / i_ls_axil_arvalid / o_ls_axil_arready / o_ls_axil_rdata / o_ls_axil_rvalid / i_ls_axil_rready: same widths and meanings for the LSU
- o_axil_araddr  out  ADDR_WIDTH  slave read address (registered)
- o_axil_arvalid  out  1  slave AR valid (registered)
- i_axil_arready  in  1  slave AR ready
- i_axil_rdata  in  DATA_WIDTH  slave read data
- i_axil_rvalid  in  1  slave R valid
- o_axil_rready  out  1  slave R ready
- o_grant  out  1  owner of current transaction: 0 fetch, 1 LSU; meaningful only while o_busy
- o_busy  out  1  high in ADDR and DATA states

## Operation
- FSM states: IDLE, ADDR, DATA. Reset -> IDLE.
- IDLE: winner chosen combinationally from arvalids. Only LSU -> LSU; only fetch -> fetch; both -> LSU, unless starve_cnt == STARVE_LIMIT, then fetch. o_<winner>_arready = 1 in IDLE (combinational, may depend on arvalid); loser's arready = 0. On winner handshake: latch araddr into o_axil_araddr, latch grant, set o_axil_arvalid, go ADDR.
- ADDR: hold o_axil_arvalid=1 and o_axil_araddr stable until i_axil_arready; then clear arvalid, go DATA. Both master arready = 0.
- DATA: o_<grant>_rvalid = i_axil_rvalid; other master's rvalid = 0; o_axil_rready = i_<grant>_rready. On i_axil_rvalid & o_axil_rready -> IDLE.
- o_if_axil_rdata and o_ls_axil_rdata both driven directly from i_axil_rdata; only rvalid qualifies them.
- starve_cnt (width clog2(STARVE_LIMIT+1)): on LSU grant while fetch arvalid high -> increment (saturates at STARVE_LIMIT); on fetch grant, or any IDLE cycle with fetch arvalid low -> 0.
- Not a transaction: masters' AR held by them per AXI (valid stays until ready); arbiter never drops an accepted request.

## Timing
- Reset values: state IDLE, o_axil_arvalid 0, o_axil_araddr 0, o_grant 0, o_busy 0, starve_cnt 0; all master arready and rvalid 0 while rst is high; o_axil_rready 0.
- Master AR handshake at cycle T -> o_axil_arvalid high at T+1. Zero-wait slave: slave AR at T+1, DATA at T+2, rvalid forwarded same cycle it arrives (combinational), R handshake at cycle D -> IDLE at D+1; next master AR handshake earliest D+1. Minimum 3 cycles/transaction, one R-to-AR bubble.
- Slave R backpressure: master rready low holds o_axil_rready low; arbiter stays in DATA.
- Slave response arriving in IDLE/ADDR is not forwarded (o_axil_rready 0).
- Reset mid-ADDR or mid-DATA: back to IDLE next cycle, in-flight transaction abandoned; slave shares rst and must abandon too.
- Simultaneous arrival of both arvalids in the same IDLE cycle is the contested case; a request arriving during ADDR/DATA waits until IDLE.

## Test plan
- Fetch-only read 0x0000_0004, zero-wait slave -> o_axil_araddr=0x4 one cycle after handshake, o_if_axil_rvalid with slave data, o_ls_axil_rvalid stays 0, back to IDLE, o_grant=0.
- Fetch 0x100 and LSU 0x200 both valid in same cycle -> LSU transaction (0x200, o_grant=1) completes first, fetch (0x100) issued in the following IDLE.
- Both masters requesting continuously, STARVE_LIMIT=4 -> grant sequence L,L,L,L,F,L,L,L,L,F; no fetch wait exceeds 4 transactions.
- Slave holds arready low 3 cycles -> o_axil_arvalid=1 and o_axil_araddr constant for all 3 cycles; both master arready 0; single AR handshake.
- LSU holds rready low 2 cycles after slave rvalid -> o_axil_rready low those cycles, data delivered on cycle rready rises, exactly one R handshake.
- Assert rst during DATA -> next cycle IDLE, o_busy 0, o_axil_arvalid 0, all rvalid 0, starve_cnt 0; next request served normally.
